// File: rtl/ps2_pkg.sv
// ps2_pkg: constants shared by the PS/2 keyboard receiver.
//   FRAME_LEN  - bits per PS/2 frame (start, 8 data, parity, stop)
//   BREAK_CODE - scan-code prefix a keyboard sends on key release
package ps2_pkg;

  localparam int         FRAME_LEN  = 11;
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: receive byte buffer for the PS/2 keyboard.
//   clk, clrn     - clock, async active-low reset (pointers only; storage unreset)
//   push, wdata   - write request and byte; ignored when full unless a pop frees a slot
//   pop           - read request; ignored when empty
//   rdata         - entry at the read pointer (combinational)
//   empty, full   - occupancy flags from extended-pointer compare
module ps2_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the write lands in, so full+pop still accepts.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver with a scan-code FIFO.
//   clk, clrn   - system clock, async active-low reset
//   ps2_clk     - keyboard clock (async), synchronized and falling-edge detected
//   ps2_data    - keyboard serial data, sampled on each detected falling edge
//   nextdata_n  - active-low pop request, honoured only while ready=1
//   data        - oldest unread byte (valid while ready=1)
//   ready       - buffer non-empty
//   overflow    - sticky: an accepted byte was dropped because the buffer was full
// Build option: define PS2_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic CHECK_PARITY = 1'b1;
`else
  localparam logic CHECK_PARITY = 1'b0;
`endif

  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

  logic [2:0]           ps2_clk_sync;
  logic                 fall;
  logic [3:0]           bit_cnt;
  logic [FRAME_LEN-1:0] frame;       // bit 0 = start, [8:1] = data, 9 = parity, 10 = stop
  logic                 frame_done;  // full frame captured last cycle
  logic                 parity_ok;
  logic                 frame_ok;
  logic                 empty, full;

  assign fall = ps2_clk_sync[2] & ~ps2_clk_sync[1];

  // Frame bits shift in from the top so the first (start) bit ends up at bit 0.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk_sync <= 3'b111;
      bit_cnt      <= '0;
      frame        <= '0;
      frame_done   <= 1'b0;
    end else begin
      ps2_clk_sync <= {ps2_clk_sync[1:0], ps2_clk};
      frame_done   <= 1'b0;
      if (fall) begin
        frame <= {ps2_data, frame[FRAME_LEN-1:1]};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign parity_ok = ~CHECK_PARITY | odd_parity_ok(frame[9:1]);
  assign frame_ok  = frame_done & ~frame[0] & frame[10] & parity_ok;

  ps2_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (frame_ok),
    .pop   (~nextdata_n),
    .wdata (frame[8:1]),
    .rdata (data),
    .empty (empty),
    .full  (full)
  );

  assign ready = ~empty;

  // full implies non-empty, so a low nextdata_n is a real pop that makes room.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                            overflow <= 1'b0;
    else if (frame_ok && full && nextdata_n) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
module tb_ps2_keyboard;

  localparam int DEPTH = 8;
  localparam int H     = 8;   // clk cycles per ps2_clk half period
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk, clrn, ps2_clk, ps2_data, nd_man, auto_pop, nextdata_n;
  logic [7:0] data;
  logic       ready, overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];     // reference buffer contents
  logic [7:0] cap[$];   // bytes seen while auto-popping
  bit         ovf;
  int         multi_cnt;
  logic       prev_ready;

  assign nextdata_n = auto_pop ? ~ready : nd_man;

  ps2_keyboard #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Auto-pop monitor: every byte should be visible for exactly one cycle.
  always @(negedge clk) begin
    if (auto_pop && ready) begin
      cap.push_back(data);
      if (prev_ready) multi_cnt++;
    end
    prev_ready = ready;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Frame model: accepted iff start=0, stop=1 and (when enabled) odd parity.
  function automatic bit accepts(input logic [10:0] bits);
    return !bits[0] && bits[10] && (!PAR || (^bits[9:1]));
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic start_b,
                                           input logic stop_b, input logic par_flip);
    logic p;
    p = ~(^b) ^ par_flip;
    return {stop_b, p, b, start_b};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  // Model-tracked frame send.
  task automatic send_model(input logic [10:0] bits, input int gap);
    if (accepts(bits)) begin
      if (q.size() < DEPTH) q.push_back(bits[8:1]);
      else ovf = 1'b1;
    end
    send_bits(bits, 11, gap);
  endtask

  task automatic pop_one();
    @(posedge clk); #1 nd_man = 1'b0;
    @(posedge clk); #1 nd_man = 1'b1;
  endtask

  task automatic drain_check(input string nm);
    while (q.size() > 0) begin
      @(negedge clk);
      chk({nm, "_ready"}, ready, 1'b1);
      chk({nm, "_data"}, data, q[0]);
      pop_one();
      void'(q.pop_front());
    end
    @(negedge clk);
    chk({nm, "_empty"}, ready, 1'b0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       start_b, stop_b, par_flip;
    logic       exp_ready;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tv[8];

  initial begin
    logic [7:0] seq[8];
    logic [10:0] fb;
    int k, kind;

    tv[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C};
    tv[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0};
    tv[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tv[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF};
    tv[4] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[5] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[6] = '{8'h1C, 1'b0, 1'b1, 1'b1, !PAR, 8'h1C};
    tv[7] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A};

    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nd_man = 1'b1; auto_pop = 1'b0;
    ovf = 1'b0; multi_cnt = 0; prev_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    @(posedge clk); #1 clrn = 1'b1;
    repeat (3) @(posedge clk);

    // Table vectors, each applied to an empty buffer.
    for (int i = 0; i < 8; i++) begin
      send_bits(mk_frame(tv[i].b, tv[i].start_b, tv[i].stop_b, tv[i].par_flip), 11, 10);
      @(negedge clk);
      chk($sformatf("tv%0d_ready", i), ready, tv[i].exp_ready);
      if (tv[i].exp_ready) begin
        chk($sformatf("tv%0d_data", i), data, tv[i].exp_data);
        pop_one();
        @(negedge clk);
        chk($sformatf("tv%0d_popped", i), ready, 1'b0);
      end
    end

    // Single byte with nextdata_n tied to ~ready.
    auto_pop = 1'b1; cap.delete(); multi_cnt = 0;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1, 1'b0), 11, 10);
    @(negedge clk);
    chk("auto1_count", cap.size(), 1);
    if (cap.size() == 1) chk("auto1_data", cap[0], 8'h1C);
    chk("auto1_ready_low", ready, 1'b0);

    // Make/break sequence, two short inter-frame gaps.
    seq = '{8'h1C, 8'hF0, 8'h1C, 8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};
    cap.delete();
    for (int i = 0; i < 8; i++)
      send_bits(mk_frame(seq[i], 1'b0, 1'b1, 1'b0), 11, (i == 2 || i == 5) ? 2 : 20);
    @(negedge clk);
    chk("seq_count", cap.size(), 8);
    for (int i = 0; i < 8 && i < cap.size(); i++) chk($sformatf("seq_byte%0d", i), cap[i], seq[i]);
    chk("seq_one_cycle", multi_cnt, 0);
    chk("seq_overflow", overflow, 1'b0);
    auto_pop = 1'b0;

    // Bad framing, then recovery.
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1, 1'b0), 11, 10);
    @(negedge clk); chk("bad_start_ready", ready, 1'b0);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0, 1'b0), 11, 10);
    @(negedge clk); chk("bad_stop_ready", ready, 1'b0);
    send_model(mk_frame(8'h1B, 1'b0, 1'b1, 1'b0), 10);
    drain_check("recover");

    // Nine frames into an eight-deep buffer.
    for (int i = 1; i <= 9; i++) send_model(mk_frame(8'(i), 1'b0, 1'b1, 1'b0), 20);
    @(negedge clk);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_model", overflow, ovf);
    drain_check("ovf_drain");
    chk("ovf_sticky", overflow, 1'b1);

    // Reset in the middle of a frame.
    send_bits(mk_frame(8'h1B, 1'b0, 1'b1, 1'b0), 5, 3);
    @(posedge clk); #1 clrn = 1'b0;
    @(negedge clk);
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_overflow", overflow, 1'b0);
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1; ovf = 1'b0;
    repeat (3) @(posedge clk);
    send_model(mk_frame(8'h1B, 1'b0, 1'b1, 1'b0), 10);
    @(negedge clk);
    chk("midrst_count", ready, 1'b1);
    drain_check("midrst");

    // Randomized frames and pops against the queue model.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      fb = mk_frame(8'($urandom), kind == 0, kind != 1, kind == 2);
      send_model(fb, $urandom_range(2, 30));
      @(negedge clk);
      chk($sformatf("rnd%0d_ready", it), ready, q.size() > 0);
      chk($sformatf("rnd%0d_ovf", it), overflow, ovf);
      if (q.size() > 0) chk($sformatf("rnd%0d_data", it), data, q[0]);
      k = $urandom_range(0, q.size());
      for (int j = 0; j < k; j++) begin
        @(negedge clk);
        chk($sformatf("rnd%0d_pop%0d", it, j), data, q[0]);
        pop_one();
        void'(q.pop_front());
      end
    end
    drain_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
